alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Request-side front end for the ALU top. It accepts one operation at a time on a valid/ready request port and drives the ALU operand and function inputs, holding them stable. It waits the fixed ALU pipeline latency, then captures the result and flag of the unit selected by the upper function bits. It returns that result on a valid/ready response port, and raises an error bit if the selected unit's flag is not asserted.

## Interface
- IN_WIDTH, 8, operand width; matches ALU inWidth
- OUT_WIDTH, 16, result width; matches ALU outWidth
- ALU_LAT, 2, ALU register stages (decoder enable stage plus unit output stage); minimum 1
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a, req_b  in  IN_WIDTH  operands
- req_fun  in  4  ALU function code; [3:2] selects the unit, [1:0] selects the operation
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  OUT_WIDTH  captured result
- rsp_carry  out  1  captured Carry_OUT; 0 for non-arith units
- rsp_unit  out  2  req_fun[3:2] of the completed operation
- rsp_err  out  1  selected unit flag was low at capture
- alu_a, alu_b  out  IN_WIDTH  to ALU A/B
- alu_fun  out  4  to ALU ALU_FUN
- alu_arith_out, alu_logic_out, alu_shift_out  in  OUT_WIDTH  ALU unit results
- alu_cmp_out  in  4  ALU compare result
- alu_carry_out  in  1  ALU carry
- alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag  in  1  ALU unit valid flags

## Operation
- Unit codes: 00 arith, 01 logic, 10 cmp, 11 shift.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register req_a/req_b/req_fun into alu_a/alu_b/alu_fun.
  - Load the wait counter with ALU_LAT and go to WAIT.
- WAIT:
  - req_ready=0; alu_* outputs held unchanged.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, capture:
    - rsp_data from the selected unit; cmp_out is zero-extended to OUT_WIDTH.
    - rsp_carry = alu_carry_out for arith, else 0.
    - rsp_err = ~(selected flag).
    - rsp_unit = alu_fun[3:2].
  - Go to RESP.
- RESP:
  - rsp_valid=1; response fields stable until handshake.
  - On rsp_ready, go to IDLE. No request is accepted in the same cycle.
- Flags from non-selected units are ignored.
- A stale flag from an earlier operation on the same unit is irrelevant, because capture happens at a fixed cycle.
- alu_* outputs keep the last operation's values while IDLE, so the ALU sees no spurious operand changes.

## Timing
- Reset (RST=0 at an edge):
  - State goes to IDLE.
  - All outputs are cleared: alu_a, alu_b, alu_fun, rsp_data, rsp_carry, rsp_unit and rsp_err to 0; req_ready=1 and rsp_valid=0 on the next cycle.
  - An in-flight operation is abandoned with no response. Reset mid-RESP drops rsp_valid on the following cycle.
- Latency:
  - Request accepted at edge E0; alu_* valid after E0.
  - Capture occurs at edge E0+ALU_LAT+1; rsp_valid is high after that edge.
  - With the default ALU_LAT=2, rsp_valid rises 3 cycles after acceptance.
- Throughput: one operation per ALU_LAT+3 cycles when rsp_ready is held high.
- Backpressure: rsp_ready low holds RESP indefinitely; req_ready stays 0 throughout.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.
- rsp_ready while not in RESP has no effect.

## Structure
- Shared package alu_pkg:
  - unit code constants UNIT_ARITH/LOGIC/CMP/SHIFT
  - sequencer state enum
  - 4-bit function code constants used by the ALU units
- Natural sub-module: alu_result_mux, a combinational selector from the unit code and ALU inputs to {data, carry, flag}. It is reusable by any other ALU client.
- Sequencer proper: FSM, wait counter, operand and response registers.

## Test plan
- Reset held 3 cycles, then released: req_ready=1, rsp_valid=0, alu_fun=0000, all response fields 0.
- Arith add, req_fun=0000, A=8'd200, B=8'd100, rsp_ready=1, real ALU attached:
  - rsp_valid exactly 3 cycles after acceptance.
  - rsp_data=16'h012C, rsp_unit=00, rsp_err=0; rsp_carry equals alu_carry_out.
- Logic op, req_fun=0100, A=8'hF0, B=8'h3C, then compare op req_fun=1000 back-to-back:
  - Each response matches the unit output; cmp result zero-extended (e.g. 4'b0010 gives 16'h0002).
  - Second req_ready only after the first response handshake.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid:
  - Response fields constant.
  - req_ready=0; a new req_valid is not accepted until after the handshake.
- Stub ALU never asserts shift flag, req_fun=1100: response arrives at normal latency with rsp_err=1, rsp_unit=11.
- RST pulsed low during WAIT: no response appears; next request completes normally with correct data.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: unit codes, ALU function codes and sequencer state shared by ALU clients
package alu_pkg;
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;
    localparam logic [3:0] FUN_ADD  = 4'b0000;
    localparam logic [3:0] FUN_SUB  = 4'b0001;
    localparam logic [3:0] FUN_AND  = 4'b0100;
    localparam logic [3:0] FUN_OR   = 4'b0101;
    localparam logic [3:0] FUN_NAND = 4'b0110;
    localparam logic [3:0] FUN_NOR  = 4'b0111;
    localparam logic [3:0] FUN_CMP  = 4'b1000;
    localparam logic [3:0] FUN_SHL  = 4'b1100;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} seq_state_e;
endpackage

// File: rtl/alu_result_mux.sv
// alu_result_mux: picks data, carry and valid flag of the ALU unit named by unit_i
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int OUT_WIDTH = 16
) (
    input  logic [1:0]           unit_i,
    input  logic [OUT_WIDTH-1:0] arith_out_i,
    input  logic [OUT_WIDTH-1:0] logic_out_i,
    input  logic [3:0]           cmp_out_i,
    input  logic [OUT_WIDTH-1:0] shift_out_i,
    input  logic                 carry_i,
    input  logic                 arith_flag_i,
    input  logic                 logic_flag_i,
    input  logic                 cmp_flag_i,
    input  logic                 shift_flag_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 carry_o,
    output logic                 flag_o
);
    always_comb begin
        data_o  = unit_i == UNIT_ARITH ? arith_out_i :
                  unit_i == UNIT_LOGIC ? logic_out_i :
                  unit_i == UNIT_CMP   ? OUT_WIDTH'(cmp_out_i) : shift_out_i;
        carry_o = unit_i == UNIT_ARITH && carry_i;
        flag_o  = unit_i == UNIT_ARITH ? arith_flag_i :
                  unit_i == UNIT_LOGIC ? logic_flag_i :
                  unit_i == UNIT_CMP   ? cmp_flag_i : shift_flag_i;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-at-a-time request/response front end that waits the fixed ALU latency
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int ALU_LAT   = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IN_WIDTH-1:0]  req_a,
    input  logic [IN_WIDTH-1:0]  req_b,
    input  logic [3:0]           req_fun,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_WIDTH-1:0] rsp_data,
    output logic                 rsp_carry,
    output logic [1:0]           rsp_unit,
    output logic                 rsp_err,
    output logic [IN_WIDTH-1:0]  alu_a,
    output logic [IN_WIDTH-1:0]  alu_b,
    output logic [3:0]           alu_fun,
    input  logic [OUT_WIDTH-1:0] alu_arith_out,
    input  logic [OUT_WIDTH-1:0] alu_logic_out,
    input  logic [OUT_WIDTH-1:0] alu_shift_out,
    input  logic [3:0]           alu_cmp_out,
    input  logic                 alu_carry_out,
    input  logic                 alu_arith_flag,
    input  logic                 alu_logic_flag,
    input  logic                 alu_cmp_flag,
    input  logic                 alu_shift_flag
);
    localparam int CW = $clog2(ALU_LAT + 1);
    seq_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0] fun_q, fun_d;
    logic [OUT_WIDTH-1:0] data_q, data_d, mux_data;
    logic carry_q, carry_d, err_q, err_d, mux_carry, mux_flag;
    logic [1:0] unit_q, unit_d;

    alu_result_mux #(.OUT_WIDTH(OUT_WIDTH)) u_mux (
        .unit_i      (fun_q[3:2]),
        .arith_out_i (alu_arith_out),
        .logic_out_i (alu_logic_out),
        .cmp_out_i   (alu_cmp_out),
        .shift_out_i (alu_shift_out),
        .carry_i     (alu_carry_out),
        .arith_flag_i(alu_arith_flag),
        .logic_flag_i(alu_logic_flag),
        .cmp_flag_i  (alu_cmp_flag),
        .shift_flag_i(alu_shift_flag),
        .data_o      (mux_data),
        .carry_o     (mux_carry),
        .flag_o      (mux_flag)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        data_d  = data_q;
        carry_d = carry_q;
        unit_d  = unit_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                a_d     = req_a;
                b_d     = req_b;
                fun_d   = req_fun;
                cnt_d   = CW'(ALU_LAT);
                state_d = S_WAIT;
            end
            // capture lands on a fixed cycle, so earlier flags on the same unit never matter
            S_WAIT: if (cnt_q == '0) begin
                data_d  = mux_data;
                carry_d = mux_carry;
                err_d   = ~mux_flag;
                unit_d  = fun_q[3:2];
                state_d = S_RESP;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            unit_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            unit_q  <= unit_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_data  = data_q;
    assign rsp_carry = carry_q;
    assign rsp_unit  = unit_q;
    assign rsp_err   = err_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_fun   = fun_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks against a two-stage ALU model whose shift flag never fires
module tb_alu_op_sequencer;
    import alu_pkg::*;
    localparam int IW = 8;
    localparam int OW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1;
    logic [IW-1:0] req_a = '0, req_b = '0, alu_a, alu_b;
    logic [3:0] req_fun = '0, alu_fun, alu_cmp_out;
    logic [OW-1:0] rsp_data, alu_arith_out, alu_logic_out, alu_shift_out;
    logic rsp_carry, rsp_err, alu_carry_out;
    logic [1:0] rsp_unit;
    logic alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
    logic [IW-1:0] s1_a, s1_b;
    logic [3:0] s1_f;
    logic [OW-1:0] sum_w;
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    alu_op_sequencer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ALU_LAT(2)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_unit(rsp_unit), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out),
        .alu_shift_out(alu_shift_out), .alu_cmp_out(alu_cmp_out),
        .alu_carry_out(alu_carry_out),
        .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
        .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag)
    );

    always_comb sum_w = s1_f[0] ? OW'(s1_a) - OW'(s1_b) : OW'(s1_a) + OW'(s1_b);

    always @(posedge CLK) begin
        s1_a <= alu_a;
        s1_b <= alu_b;
        s1_f <= alu_fun;
        alu_arith_out <= sum_w;
        alu_carry_out <= sum_w[IW];
        alu_logic_out <= OW'(s1_f[1:0] == 2'd0 ? s1_a & s1_b :
                             s1_f[1:0] == 2'd1 ? s1_a | s1_b :
                             s1_f[1:0] == 2'd2 ? ~(s1_a & s1_b) : ~(s1_a | s1_b));
        alu_cmp_out   <= {1'b0, s1_a < s1_b, s1_a > s1_b, s1_a == s1_b};
        alu_shift_out <= OW'(s1_a) << 1;
        alu_arith_flag <= s1_f[3:2] == UNIT_ARITH;
        alu_logic_flag <= s1_f[3:2] == UNIT_LOGIC;
        alu_cmp_flag   <= s1_f[3:2] == UNIT_CMP;
        alu_shift_flag <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [3:0] fun);
        check("req_ready_before", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_fun = fun;
        tick();
        req_valid = 1'b0;
        check("alu_fun_accept", 32'(alu_fun), 32'(fun));
        check("alu_a_accept", 32'(alu_a), 32'(a));
        check("req_ready_busy", 32'(req_ready), 0);
    endtask

    task automatic rsp_expect(input logic [OW-1:0] d, input logic c, input logic [1:0] u, input logic e);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 20);
        check("latency", 32'(n), 3);
        check("rsp_data", 32'(rsp_data), 32'(d));
        check("rsp_carry", 32'(rsp_carry), 32'(c));
        check("rsp_unit", 32'(rsp_unit), 32'(u));
        check("rsp_err", 32'(rsp_err), 32'(e));
    endtask

    initial begin
        repeat (3) tick();
        RST = 1'b1;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_alu_fun", 32'(alu_fun), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_fields", {29'd0, rsp_carry, rsp_unit} | 32'(rsp_err), 0);

        issue(8'd200, 8'd100, FUN_ADD);
        rsp_expect(16'h012C, 1'b1, UNIT_ARITH, 1'b0);
        tick();
        check("add_done_valid", 32'(rsp_valid), 0);
        check("add_done_ready", 32'(req_ready), 1);

        issue(8'hF0, 8'h3C, FUN_AND);
        rsp_expect(16'h0030, 1'b0, UNIT_LOGIC, 1'b0);
        req_valid = 1'b1;
        req_fun = FUN_CMP;
        check("b2b_ready_in_resp", 32'(req_ready), 0);
        tick();
        check("b2b_not_taken", 32'(alu_fun), 32'(FUN_AND));
        check("b2b_ready_after_hs", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check("b2b_cmp_taken", 32'(alu_fun), 32'(FUN_CMP));
        rsp_expect(16'h0002, 1'b0, UNIT_CMP, 1'b0);
        tick();

        rsp_ready = 1'b0;
        issue(8'd9, 8'd5, FUN_SUB);
        rsp_expect(16'h0004, 1'b0, UNIT_ARITH, 1'b0);
        req_valid = 1'b1;
        req_a = 8'h0F;
        req_b = 8'h01;
        req_fun = FUN_ADD;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_data", 32'(rsp_data), 32'h4);
            check("bp_ready", 32'(req_ready), 0);
            check("bp_alu_fun", 32'(alu_fun), 32'(FUN_SUB));
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(rsp_valid), 0);
        check("bp_hs_not_taken", 32'(alu_fun), 32'(FUN_SUB));
        tick();
        req_valid = 1'b0;
        check("bp_next_fun", 32'(alu_fun), 32'(FUN_ADD));
        check("bp_next_a", 32'(alu_a), 32'h0F);
        rsp_expect(16'h0010, 1'b0, UNIT_ARITH, 1'b0);
        tick();

        issue(8'h81, 8'h00, FUN_SHL);
        rsp_expect(16'h0102, 1'b0, UNIT_SHIFT, 1'b1);
        tick();

        issue(8'd1, 8'd2, FUN_ADD);
        tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("mid_rst_alu_a", 32'(alu_a), 0);
        check("mid_rst_alu_fun", 32'(alu_fun), 0);
        check("mid_rst_data", 32'(rsp_data), 0);
        check("mid_rst_err", 32'(rsp_err), 0);
        check("mid_rst_unit", 32'(rsp_unit), 0);
        check("mid_rst_ready", 32'(req_ready), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_rsp", 32'(rsp_valid), 0);
        end
        issue(8'd3, 8'd4, FUN_ADD);
        rsp_expect(16'h0007, 1'b0, UNIT_ARITH, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
